operand_fetch: RTL

Read-side companion of the CPU register file: issues the two register-file read addresses for the instruction in decode and resolves RAW hazards. Forwarding comes from EX, MEM and WB; a load-use dependency stalls decode and inserts a bubble. The resulting operands are registered into the ID/EX pipeline register under a valid/ready handshake. Sits between decode and the EX stage of the five-stage pipeline.

---
 rtl/operand_fetch_pkg.sv | 26 ++
 rtl/operand_fetch_fwd_mux.sv | 63 ++++++
 rtl/operand_fetch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared CPU constants for the read side of the register file.
//               Holds the data and address widths, the hardwired-zero register
//               index, and the encoding used to pick an operand source.
// Revision    : 1.0  initial release
// ============================================================================
package operand_fetch_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_W    = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Operand source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    FWD_ZERO = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_RF   = 3'd4
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Resolves one source operand. Compares the source address
//               against the EX, MEM and WB producers and returns the youngest
//               matching value; r0 always reads as zero. Purely combinational.
// Ports       : i_addr           source register index
//               i_ex_en/addr/data    EX producer (enable already excludes loads)
//               i_mem_en/addr/data   MEM producer
//               i_wb_en/addr/data    WB producer (same as the RF write port)
//               i_rf_data        register-file read data for i_addr
//               o_data           resolved operand
// Revision    : 1.0  initial release
// ============================================================================
module fwd_mux #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 5
) (
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic                 i_ex_en,
  input  logic [ADDR_W-1:0]    i_ex_addr,
  input  logic [WORD_SIZE-1:0] i_ex_data,
  input  logic                 i_mem_en,
  input  logic [ADDR_W-1:0]    i_mem_addr,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  input  logic                 i_wb_en,
  input  logic [ADDR_W-1:0]    i_wb_addr,
  input  logic [WORD_SIZE-1:0] i_wb_data,
  input  logic [WORD_SIZE-1:0] i_rf_data,
  output logic [WORD_SIZE-1:0] o_data
);
  import operand_fetch_pkg::*;

  fwd_sel_e w_sel;

  // Youngest producer wins. WB must still be forwarded because the register
  // file writes on the same edge and its read returns the old value.
  always_comb begin
    w_sel = FWD_RF;
    if (i_addr == REG_ZERO) begin
      w_sel = FWD_ZERO;
    end else if (i_ex_en && (i_ex_addr == i_addr)) begin
      w_sel = FWD_EX;
    end else if (i_mem_en && (i_mem_addr == i_addr)) begin
      w_sel = FWD_MEM;
    end else if (i_wb_en && (i_wb_addr == i_addr)) begin
      w_sel = FWD_WB;
    end
  end

  always_comb begin
    o_data = i_rf_data;
    case (w_sel)
      FWD_ZERO: o_data = '0;
      FWD_EX:   o_data = i_ex_data;
      FWD_MEM:  o_data = i_mem_data;
      FWD_WB:   o_data = i_wb_data;
      default:  o_data = i_rf_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Issues register-file read addresses for the instruction in
//               decode, forwards results from EX/MEM/WB, stalls one cycle on a
//               load-use dependency, and registers the operands into the ID/EX
//               pipeline register under a valid/ready handshake.
// Ports       : clk, rst (synchronous, active-low)
//               id_*      decode-side instruction and handshake
//               rf_*      register-file read port
//               ex_fwd_data, mem_fwd_*, wb_*   forwarding sources
//               ex_*      ID/EX pipeline register and EX handshake
//               stall_count  saturating count of load-use stall cycles
// Revision    : 1.0  initial release
// ============================================================================
module operand_fetch #(
  parameter int WORD_SIZE = operand_fetch_pkg::WORD_SIZE,
  parameter int ADDR_W    = operand_fetch_pkg::ADDR_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [ADDR_W-1:0]    id_src1_addr,
  input  logic [ADDR_W-1:0]    id_src2_addr,
  input  logic [ADDR_W-1:0]    id_dst_addr,
  input  logic                 id_wr_en,
  input  logic                 id_is_load,
  output logic [ADDR_W-1:0]    rf_src1_addr,
  output logic [ADDR_W-1:0]    rf_src2_addr,
  input  logic [WORD_SIZE-1:0] rf_src1_data,
  input  logic [WORD_SIZE-1:0] rf_src2_data,
  input  logic [WORD_SIZE-1:0] ex_fwd_data,
  input  logic                 mem_fwd_valid,
  input  logic                 mem_fwd_wr_en,
  input  logic [ADDR_W-1:0]    mem_fwd_addr,
  input  logic [WORD_SIZE-1:0] mem_fwd_data,
  input  logic                 wb_wr_en,
  input  logic [ADDR_W-1:0]    wb_dst_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [WORD_SIZE-1:0] ex_op1,
  output logic [WORD_SIZE-1:0] ex_op2,
  output logic [ADDR_W-1:0]    ex_dst_addr,
  output logic                 ex_wr_en,
  output logic                 ex_is_load,
  output logic [CNT_W-1:0]     stall_count
);
  import operand_fetch_pkg::*;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic                 r_ex_valid;
  logic [WORD_SIZE-1:0] r_ex_op1;
  logic [WORD_SIZE-1:0] r_ex_op2;
  logic [ADDR_W-1:0]    r_ex_dst_addr;
  logic                 r_ex_wr_en;
  logic                 r_ex_is_load;
  logic [CNT_W-1:0]     r_stall_count;

  logic [WORD_SIZE-1:0] w_op1;
  logic [WORD_SIZE-1:0] w_op2;
  logic                 w_ex_fwd_en;
  logic                 w_load_in_ex;
  logic                 w_hazard;
  logic                 w_advance;

  assign rf_src1_addr = id_src1_addr;
  assign rf_src2_addr = id_src2_addr;

  // A load in EX has no result yet, so it is never a forwarding source; it
  // is the load-use hazard instead.
  assign w_ex_fwd_en  = r_ex_valid && r_ex_wr_en && !r_ex_is_load;
  assign w_load_in_ex = r_ex_valid && r_ex_is_load && r_ex_wr_en
                        && (r_ex_dst_addr != REG_ZERO);
  assign w_hazard     = id_valid && w_load_in_ex
                        && ((r_ex_dst_addr == id_src1_addr)
                            || (r_ex_dst_addr == id_src2_addr));
  assign w_advance    = !r_ex_valid || ex_ready;
  assign id_ready     = w_advance && !w_hazard && rst;

  fwd_mux #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) u_fwd_src1 (
    .i_addr     (id_src1_addr),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_addr  (r_ex_dst_addr),
    .i_ex_data  (ex_fwd_data),
    .i_mem_en   (mem_fwd_valid && mem_fwd_wr_en),
    .i_mem_addr (mem_fwd_addr),
    .i_mem_data (mem_fwd_data),
    .i_wb_en    (wb_wr_en),
    .i_wb_addr  (wb_dst_addr),
    .i_wb_data  (wb_data),
    .i_rf_data  (rf_src1_data),
    .o_data     (w_op1)
  );

  fwd_mux #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) u_fwd_src2 (
    .i_addr     (id_src2_addr),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_addr  (r_ex_dst_addr),
    .i_ex_data  (ex_fwd_data),
    .i_mem_en   (mem_fwd_valid && mem_fwd_wr_en),
    .i_mem_addr (mem_fwd_addr),
    .i_mem_data (mem_fwd_data),
    .i_wb_en    (wb_wr_en),
    .i_wb_addr  (wb_dst_addr),
    .i_wb_data  (wb_data),
    .i_rf_data  (rf_src2_data),
    .o_data     (w_op2)
  );

  // ID/EX register. A bubble clears only the valid bit; payload holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_op1      <= '0;
      r_ex_op2      <= '0;
      r_ex_dst_addr <= '0;
      r_ex_wr_en    <= 1'b0;
      r_ex_is_load  <= 1'b0;
    end else if (w_advance) begin
      if (id_valid && !w_hazard) begin
        r_ex_valid    <= 1'b1;
        r_ex_op1      <= w_op1;
        r_ex_op2      <= w_op2;
        r_ex_dst_addr <= id_dst_addr;
        r_ex_wr_en    <= id_wr_en;
        r_ex_is_load  <= id_is_load;
      end else begin
        r_ex_valid    <= 1'b0;
      end
    end
  end

  // Counts every hazard cycle, including those overlapping EX back-pressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (w_hazard && (r_stall_count != c_cnt_max)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_op1      = r_ex_op1;
  assign ex_op2      = r_ex_op2;
  assign ex_dst_addr = r_ex_dst_addr;
  assign ex_wr_en    = r_ex_wr_en;
  assign ex_is_load  = r_ex_is_load;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire
